ddr_bringup_seq: RTL and testbench
==================================

# ddr_bringup_seq

DDR bring-up sequencer between the board reset input and both the external DDR3 memory controller and the system core. It drives the controller's active-low reset and qualifies the controller's PLL-lock and calibration status. The system core is held in reset until the memory is stable. Calibration failure, timeout or loss of lock re-runs the controller reset, up to a bounded retry count.

## Interface
Parameters:
- `RST_PULSE_CYC`, 16: cycles `ctrl_resetn_o` is held low per controller reset pulse.
- `LOCK_STABLE_CYC`, 256: consecutive cycles of `locked` required before lock is accepted.
- `HOLD_CYC`, 32: cycles system reset is held after calibration success.
- `CAL_TIMEOUT_CYC`, 1000000: maximum cycles from `WAIT_LOCK` entry to calibration done.
- `CNT_W`, 24: width of the shared cycle counter; must hold every count above.
- `MAX_RETRY`, 3: number of controller reset retries allowed.
- `RETRY_W`, 2: width of the retry counter.

Ports:
- `clk`  in  1  single clock for the whole block.
- `resetn`  in  1  reset, asynchronous assert, active-low. This polarity and synchronicity are decided.
- `locked_i`  in  1  controller PLL locked; asynchronous to `clk`.
- `init_done_i`  in  1  controller calibration/init done; asynchronous.
- `cal_fail_i`  in  1  controller calibration failed; asynchronous.
- `ctrl_resetn_o`  out  1  active-low reset to the memory controller.
- `sys_rst_o`  out  1  active-high reset to the system core.
- `ready_o`  out  1  memory usable; high only in `RUN`.
- `fail_o`  out  1  sticky bring-up failure.
- `retry_cnt_o`  out  RETRY_W  retries consumed.
- `state_o`  out  3  current state, for debug.

## Operation
- Input synchronization:
  - `locked_i`, `init_done_i` and `cal_fail_i` each pass through a 2-flop synchronizer; the results are `locked_s`, `init_done_s` and `cal_fail_s`.
  - All decisions use only the synchronized values.
- State encoding: `CTRL_RST`=1, `WAIT_LOCK`=2, `WAIT_CAL`=3, `HOLD`=4, `RUN`=5, `FAIL`=6.
- `CTRL_RST`: `ctrl_resetn_o`=0. The state lasts exactly `RST_PULSE_CYC` cycles, then goes to `WAIT_LOCK`.
- `WAIT_LOCK`:
  - `ctrl_resetn_o`=1.
  - The stability counter increments while `locked_s`=1 and clears to 0 whenever `locked_s`=0.
  - On reaching `LOCK_STABLE_CYC`, go to `WAIT_CAL`.
- Timeout counter:
  - Cleared on `WAIT_LOCK` entry; runs through `WAIT_LOCK` and `WAIT_CAL`.
  - Reaching `CAL_TIMEOUT_CYC` is a failure event.
- `WAIT_CAL`, checked in this priority order:
  1. `cal_fail_s`=1 → failure event.
  2. `locked_s`=0 → failure event.
  3. `init_done_s`=1 → go to `HOLD`.
  - If `cal_fail_s` and `init_done_s` are both high in the same cycle, failure wins.
- `HOLD`:
  - Lasts `HOLD_CYC` cycles, then goes to `RUN`.
  - `locked_s`=0 or `init_done_s`=0 during `HOLD` → failure event.
- `RUN`: `sys_rst_o`=0, `ready_o`=1. `locked_s`=0 or `init_done_s`=0 → failure event.
- Failure event:
  - Retry permitted (see Configuration) and `retry_cnt` < `MAX_RETRY`: increment `retry_cnt`, go to `CTRL_RST`.
  - Otherwise go to `FAIL`.
- `FAIL`:
  - Outputs: `ctrl_resetn_o`=0, `sys_rst_o`=1, `fail_o`=1.
  - `FAIL` is absorbing; only `resetn` exits it.
- Output decode:
  - `sys_rst_o`=1 in every state except `RUN`.
  - All outputs are pure decodes of the registered state and counters; there is no input-to-output combinational path.
- Counter rule: at every state transition the shared cycle counter is cleared to 0. Exception: the timeout counter is not cleared on the `WAIT_LOCK`→`WAIT_CAL` transition.

## Timing
- While `resetn`=0, immediately (asynchronous):
  - state=`CTRL_RST`; all counters and synchronizers = 0.
  - `ctrl_resetn_o`=0, `sys_rst_o`=1, `ready_o`=0, `fail_o`=0, `retry_cnt_o`=0, `state_o`=1.
- Cycle 0 is the first rising edge with `resetn`=1. `CTRL_RST` occupies cycles 0..`RST_PULSE_CYC`-1.
- An input change is seen by the FSM 2 cycles later. The resulting output change appears 1 cycle after that (3 cycles input-to-output).
- Deasserting `resetn` mid-operation in any state restarts the sequence from `CTRL_RST`, with `retry_cnt` cleared.

## Configuration
- `DDR_CAL_RETRY_EN` defined:
  - Failure events retry as described in Operation.
  - `retry_cnt_o` reports retries consumed.
- `DDR_CAL_RETRY_EN` undefined:
  - The first failure event goes directly to `FAIL`.
  - The retry counter is not built; `retry_cnt_o` is tied to 0.

## Test plan
Bench parameters for every scenario: `RST_PULSE_CYC`=4, `LOCK_STABLE_CYC`=8, `HOLD_CYC`=4, `CAL_TIMEOUT_CYC`=100, `MAX_RETRY`=2, `DDR_CAL_RETRY_EN` defined.

- Nominal: `locked_i`=1 from reset, `init_done_i` rises at cycle 20 → `WAIT_CAL` entered at cycle 12, `RUN` at cycle 27 with `sys_rst_o`=0, `ready_o`=1.
- Lock glitch: `locked_i` low for one cycle at cycle 8 → stability count restarts; `WAIT_CAL` entry moves from cycle 12 to cycle 19.
- Calibration failure: `cal_fail_i` pulsed three times in `WAIT_CAL`:
  - First and second pulses: `ctrl_resetn_o`=0 for 4 cycles each, `retry_cnt_o`=1 then 2.
  - Third pulse: `FAIL`, `fail_o`=1 sticky, `ctrl_resetn_o` stays 0.
- Timeout: `init_done_i` never asserts → failure event 100 cycles after `WAIT_LOCK` entry; `retry_cnt_o`=1; `CTRL_RST` re-entered.
- Lock loss in `RUN`: `locked_i` drops → 3 cycles later `sys_rst_o`=1, `ready_o`=0, state=`CTRL_RST`.
- Asynchronous reset: `resetn` pulsed low mid-`RUN` and also in `FAIL` → outputs take reset values without waiting for a clock edge, `retry_cnt_o`=0. Separately, with `DDR_CAL_RETRY_EN` undefined, a single `cal_fail_i` → `FAIL`.

Source files
------------

// File: rtl/ddr_bringup_seq.sv
// ddr_bringup_seq: DDR3 controller bring-up sequencer.
// Pulses the controller reset, waits for a stable PLL lock and calibration,
// then releases the system core. Failures re-run the controller reset.
//
// Ports:
//   clk            single clock
//   resetn         asynchronous active-low reset
//   locked_i       controller PLL locked (async)
//   init_done_i    controller calibration done (async)
//   cal_fail_i     controller calibration failed (async)
//   ctrl_resetn_o  active-low reset to the memory controller
//   sys_rst_o      active-high reset to the system core
//   ready_o        memory usable (RUN only)
//   fail_o         sticky bring-up failure
//   retry_cnt_o    controller reset retries consumed
//   state_o        current state (debug)
//
// Build option: define DDR_CAL_RETRY_EN to enable controller reset retries;
// without it the first failure event is final and retry_cnt_o reads 0.
module ddr_bringup_seq #(
    parameter int unsigned RST_PULSE_CYC   = 16,
    parameter int unsigned LOCK_STABLE_CYC = 256,
    parameter int unsigned HOLD_CYC        = 32,
    parameter int unsigned CAL_TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W           = 24,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned RETRY_W         = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               locked_i,
    input  logic               init_done_i,
    input  logic               cal_fail_i,
    output logic               ctrl_resetn_o,
    output logic               sys_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        CTRL_RST  = 3'd1,
        WAIT_LOCK = 3'd2,
        WAIT_CAL  = 3'd3,
        HOLD      = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(CAL_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         meta_q, sync_q;
    logic               locked_s, init_done_s, cal_fail_s;
    logic               fail_ev;
    logic               tmo_hit;

    // Two-flop synchronizers, bit order {cal_fail, init_done, locked}.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {cal_fail_i, init_done_i, locked_i};
            sync_q <= meta_q;
        end
    end

    assign locked_s    = sync_q[0];
    assign init_done_s = sync_q[1];
    assign cal_fail_s  = sync_q[2];

`ifdef DDR_CAL_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
    logic [RETRY_W-1:0] retry_q, retry_d;

    // CTRL_RST is only re-entered from another state through a retry.
    always_comb begin
        retry_d = retry_q;
        if (state_d == CTRL_RST && state_q != CTRL_RST) begin
            retry_d = retry_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    localparam bit RETRY_EN = 1'b0;
    logic [RETRY_W-1:0] retry_q;
    assign retry_q = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= CTRL_RST;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        fail_ev = 1'b0;

        unique case (state_q)
            CTRL_RST: begin
                if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // cnt_q counts consecutive locked cycles here.
                cnt_d = locked_s ? cnt_q + 1'b1 : '0;
                if (tmo_hit) begin
                    fail_ev = 1'b1;
                end else if (locked_s && cnt_q == LOCK_LAST) begin
                    state_d = WAIT_CAL;
                end
            end
            WAIT_CAL: begin
                if (cal_fail_s || !locked_s || tmo_hit) begin
                    fail_ev = 1'b1;
                end else if (init_done_s) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!locked_s || !init_done_s) begin
                    fail_ev = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s || !init_done_s) fail_ev = 1'b1;
            end
            FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = CTRL_RST;
            end
        endcase

        if (fail_ev) begin
            if (RETRY_EN && retry_q < RETRY_MAX) begin
                state_d = CTRL_RST;
            end else begin
                state_d = FAIL;
            end
        end

        if (state_d != state_q) cnt_d = '0;
    end

    // The calibration timeout spans WAIT_LOCK and WAIT_CAL as one window.
    always_comb begin
        tmo_d = '0;
        if (state_d != state_q) begin
            if (state_q == WAIT_LOCK && state_d == WAIT_CAL) begin
                tmo_d = tmo_q + 1'b1;
            end
        end else if (state_q == WAIT_LOCK || state_q == WAIT_CAL) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    assign ctrl_resetn_o = (state_q == WAIT_LOCK) || (state_q == WAIT_CAL) ||
                           (state_q == HOLD) || (state_q == RUN);
    assign sys_rst_o     = (state_q != RUN);
    assign ready_o       = (state_q == RUN);
    assign fail_o        = (state_q == FAIL);
    assign retry_cnt_o   = retry_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ddr_bringup_seq.sv
// tb_ddr_bringup_seq: directed bench for ddr_bringup_seq.
// Cycle n is the interval just before rising edge n after reset release.
module tb_ddr_bringup_seq;

    logic       clk;
    logic       resetn;
    logic       locked_i;
    logic       init_done_i;
    logic       cal_fail_i;
    logic       ctrl_resetn_o;
    logic       sys_rst_o;
    logic       ready_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    int tests;
    int fails;
    int cyc;

`ifdef DDR_CAL_RETRY_EN
    localparam logic [2:0] ST_AFTER_FAIL = 3'd1;
    localparam logic [1:0] RETRY_ONE     = 2'd1;
    localparam logic [1:0] RETRY_TWO     = 2'd2;
`else
    localparam logic [2:0] ST_AFTER_FAIL = 3'd6;
    localparam logic [1:0] RETRY_ONE     = 2'd0;
    localparam logic [1:0] RETRY_TWO     = 2'd0;
`endif

    ddr_bringup_seq #(
        .RST_PULSE_CYC  (4),
        .LOCK_STABLE_CYC(8),
        .HOLD_CYC       (4),
        .CAL_TIMEOUT_CYC(100),
        .CNT_W          (24),
        .MAX_RETRY      (2),
        .RETRY_W        (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .locked_i     (locked_i),
        .init_done_i  (init_done_i),
        .cal_fail_i   (cal_fail_i),
        .ctrl_resetn_o(ctrl_resetn_o),
        .sys_rst_o    (sys_rst_o),
        .ready_o      (ready_o),
        .fail_o       (fail_o),
        .retry_cnt_o  (retry_cnt_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic start_seq(input logic lk, input logic done);
        resetn      = 1'b0;
        locked_i    = lk;
        init_done_i = done;
        cal_fail_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        tests++;
        if (state_o !== 3'd1) begin
            fails++;
            $display("FAIL reset_state: got %0d want 1", state_o);
        end
        tests++;
        if ({ctrl_resetn_o, sys_rst_o, ready_o, fail_o} !== 4'b0100) begin
            fails++;
            $display("FAIL reset_outs: got %b want 0100",
                     {ctrl_resetn_o, sys_rst_o, ready_o, fail_o});
        end
        tests++;
        if (retry_cnt_o !== 2'd0) begin
            fails++;
            $display("FAIL reset_retry: got %0d want 0", retry_cnt_o);
        end
    endtask

    task automatic test_nominal();
        start_seq(1'b1, 1'b0);
        run_to(3);
        tests++;
        if (state_o !== 3'd1 || ctrl_resetn_o !== 1'b0) begin
            fails++;
            $display("FAIL nom_c3: state=%0d ctrl=%b want 1/0", state_o, ctrl_resetn_o);
        end
        run_to(4);
        tests++;
        if (state_o !== 3'd2 || ctrl_resetn_o !== 1'b1) begin
            fails++;
            $display("FAIL nom_c4: state=%0d ctrl=%b want 2/1", state_o, ctrl_resetn_o);
        end
        run_to(11);
        tests++;
        if (state_o !== 3'd2) begin
            fails++;
            $display("FAIL nom_c11: state=%0d want 2", state_o);
        end
        run_to(12);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL nom_c12: state=%0d want 3", state_o);
        end
        run_to(20);
        init_done_i = 1'b1;
        run_to(22);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL nom_c22: state=%0d want 3", state_o);
        end
        run_to(23);
        tests++;
        if (state_o !== 3'd4 || sys_rst_o !== 1'b1) begin
            fails++;
            $display("FAIL nom_c23: state=%0d sys=%b want 4/1", state_o, sys_rst_o);
        end
        run_to(26);
        tests++;
        if (state_o !== 3'd4 || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL nom_c26: state=%0d rdy=%b want 4/0", state_o, ready_o);
        end
        run_to(27);
        tests++;
        if ({state_o, sys_rst_o, ready_o, ctrl_resetn_o} !== {3'd5, 3'b011}) begin
            fails++;
            $display("FAIL nom_run: state=%0d sys=%b rdy=%b ctrl=%b want 5/0/1/1",
                     state_o, sys_rst_o, ready_o, ctrl_resetn_o);
        end
    endtask

    task automatic test_lock_glitch();
        start_seq(1'b1, 1'b0);
        run_to(8);
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        run_to(12);
        tests++;
        if (state_o !== 3'd2) begin
            fails++;
            $display("FAIL glitch_c12: state=%0d want 2", state_o);
        end
        run_to(18);
        tests++;
        if (state_o !== 3'd2) begin
            fails++;
            $display("FAIL glitch_c18: state=%0d want 2", state_o);
        end
        run_to(19);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL glitch_c19: state=%0d want 3", state_o);
        end
    endtask

    task automatic test_cal_fail();
        start_seq(1'b1, 1'b0);
        run_to(14);
        cal_fail_i = 1'b1;
        tick();
        cal_fail_i = 1'b0;
        run_to(16);
        tests++;
        if (state_o !== 3'd3 || ctrl_resetn_o !== 1'b1) begin
            fails++;
            $display("FAIL cf1_c16: state=%0d ctrl=%b want 3/1", state_o, ctrl_resetn_o);
        end
        run_to(17);
        tests++;
        if (state_o !== ST_AFTER_FAIL || ctrl_resetn_o !== 1'b0 ||
            retry_cnt_o !== RETRY_ONE) begin
            fails++;
            $display("FAIL cf1_c17: state=%0d ctrl=%b retry=%0d want %0d/0/%0d",
                     state_o, ctrl_resetn_o, retry_cnt_o, ST_AFTER_FAIL, RETRY_ONE);
        end
`ifdef DDR_CAL_RETRY_EN
        run_to(20);
        tests++;
        if (ctrl_resetn_o !== 1'b0) begin
            fails++;
            $display("FAIL cf1_c20: ctrl=%b want 0", ctrl_resetn_o);
        end
        run_to(21);
        tests++;
        if (state_o !== 3'd2 || ctrl_resetn_o !== 1'b1) begin
            fails++;
            $display("FAIL cf1_c21: state=%0d ctrl=%b want 2/1", state_o, ctrl_resetn_o);
        end
        run_to(29);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL cf2_c29: state=%0d want 3", state_o);
        end
        run_to(31);
        cal_fail_i = 1'b1;
        tick();
        cal_fail_i = 1'b0;
        run_to(34);
        tests++;
        if (state_o !== 3'd1 || retry_cnt_o !== 2'd2) begin
            fails++;
            $display("FAIL cf2_c34: state=%0d retry=%0d want 1/2", state_o, retry_cnt_o);
        end
        run_to(37);
        tests++;
        if (ctrl_resetn_o !== 1'b0) begin
            fails++;
            $display("FAIL cf2_c37: ctrl=%b want 0", ctrl_resetn_o);
        end
        run_to(38);
        tests++;
        if (ctrl_resetn_o !== 1'b1) begin
            fails++;
            $display("FAIL cf2_c38: ctrl=%b want 1", ctrl_resetn_o);
        end
        run_to(46);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL cf3_c46: state=%0d want 3", state_o);
        end
        run_to(48);
        cal_fail_i = 1'b1;
        tick();
        cal_fail_i = 1'b0;
        run_to(51);
        tests++;
        if ({state_o, fail_o, ctrl_resetn_o, sys_rst_o} !== {3'd6, 3'b101} ||
            retry_cnt_o !== 2'd2) begin
            fails++;
            $display("FAIL cf3_c51: state=%0d fail=%b ctrl=%b sys=%b retry=%0d want 6/1/0/1/2",
                     state_o, fail_o, ctrl_resetn_o, sys_rst_o, retry_cnt_o);
        end
`endif
        run_to(cyc + 10);
        tests++;
        if (state_o !== 3'd6 || fail_o !== 1'b1 || ctrl_resetn_o !== 1'b0) begin
            fails++;
            $display("FAIL cf_sticky: state=%0d fail=%b ctrl=%b want 6/1/0",
                     state_o, fail_o, ctrl_resetn_o);
        end
    endtask

    task automatic test_timeout();
        start_seq(1'b1, 1'b0);
        run_to(103);
        tests++;
        if (state_o !== 3'd3) begin
            fails++;
            $display("FAIL tmo_c103: state=%0d want 3", state_o);
        end
        run_to(104);
        tests++;
        if (state_o !== ST_AFTER_FAIL || retry_cnt_o !== RETRY_ONE) begin
            fails++;
            $display("FAIL tmo_c104: state=%0d retry=%0d want %0d/%0d",
                     state_o, retry_cnt_o, ST_AFTER_FAIL, RETRY_ONE);
        end
    endtask

    task automatic test_lock_loss_run();
        start_seq(1'b1, 1'b1);
        run_to(17);
        tests++;
        if (state_o !== 3'd5 || ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ll_c17: state=%0d rdy=%b want 5/1", state_o, ready_o);
        end
        run_to(20);
        locked_i = 1'b0;
        run_to(22);
        tests++;
        if (state_o !== 3'd5 || sys_rst_o !== 1'b0) begin
            fails++;
            $display("FAIL ll_c22: state=%0d sys=%b want 5/0", state_o, sys_rst_o);
        end
        run_to(23);
        tests++;
        if (state_o !== ST_AFTER_FAIL || sys_rst_o !== 1'b1 || ready_o !== 1'b0 ||
            retry_cnt_o !== RETRY_ONE) begin
            fails++;
            $display("FAIL ll_c23: state=%0d sys=%b rdy=%b retry=%0d want %0d/1/0/%0d",
                     state_o, sys_rst_o, ready_o, retry_cnt_o, ST_AFTER_FAIL, RETRY_ONE);
        end
    endtask

    task automatic test_async_reset();
        start_seq(1'b1, 1'b1);
        run_to(18);
        tests++;
        if (state_o !== 3'd5) begin
            fails++;
            $display("FAIL ar_run: state=%0d want 5", state_o);
        end
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if ({state_o, ctrl_resetn_o, sys_rst_o, ready_o, fail_o} !== {3'd1, 4'b0100}) begin
            fails++;
            $display("FAIL ar_mid_run: state=%0d ctrl=%b sys=%b rdy=%b fail=%b want 1/0/1/0/0",
                     state_o, ctrl_resetn_o, sys_rst_o, ready_o, fail_o);
        end
        start_seq(1'b1, 1'b0);
        cal_fail_i = 1'b1;
        run_to(45);
        tests++;
        if (state_o !== 3'd6 || fail_o !== 1'b1 || retry_cnt_o !== RETRY_TWO) begin
            fails++;
            $display("FAIL ar_fail: state=%0d fail=%b retry=%0d want 6/1/%0d",
                     state_o, fail_o, retry_cnt_o, RETRY_TWO);
        end
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if ({state_o, ctrl_resetn_o, sys_rst_o, ready_o, fail_o} !== {3'd1, 4'b0100} ||
            retry_cnt_o !== 2'd0) begin
            fails++;
            $display("FAIL ar_mid_fail: state=%0d fail=%b retry=%0d want 1/0/0",
                     state_o, fail_o, retry_cnt_o);
        end
        cal_fail_i = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        cyc         = 0;
        resetn      = 1'b1;
        locked_i    = 1'b0;
        init_done_i = 1'b0;
        cal_fail_i  = 1'b0;
        #2;
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_cal_fail();
        test_timeout();
        test_lock_loss_run();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
